// File: rtl/k_and_s_pkg.sv
// Shared types and default sizes for the ks_memory program/data RAM.
package k_and_s_pkg;
    localparam int KS_DATA_W = 16;
    localparam int KS_ADDR_W = 5;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } ks_mem_state_t;
endpackage

// File: rtl/ks_mem_array.sv
// Single-port synchronous RAM: registered read, write-enable, read-before-write.
module ks_mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // The read samples the old contents even when the same word is written.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/ks_memory.sv
// Processor memory with a streaming program loader; the CPU is held off
// while the loader fills all 2**ADDR_W words.
module ks_memory
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = KS_DATA_W,
    parameter int ADDR_W = KS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              write_enable,
    output logic [DATA_W-1:0] rd_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done
);
    ks_mem_state_t     state;
    logic [ADDR_W-1:0] load_ptr;
    logic              rd_vld;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // The loader owns the RAM port while loading; reset blocks any write.
    always_comb begin
        mem_addr  = ram_addr;
        mem_wdata = wr_data;
        mem_we    = write_enable;
        if (state == S_LOAD) begin
            mem_addr  = load_ptr;
            mem_wdata = load_data;
            mem_we    = load_valid;
        end
        mem_we = mem_we & rst_n;
    end

    ks_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            load_ptr  <= '0;
            load_done <= 1'b0;
            rd_vld    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            rd_vld    <= (state == S_RUN);
            if (state == S_LOAD) begin
                if (load_valid) begin
                    load_ptr <= load_ptr + 1'b1;
                    if (load_ptr == '1) begin
                        state     <= S_RUN;
                        load_done <= 1'b1;
                    end
                end
            end else if (load_start) begin
                state    <= S_LOAD;
                load_ptr <= '0;
            end
        end
    end

    // Read data is only meaningful once the registered read came from a run-mode address.
    assign rd_data    = (state == S_RUN && rd_vld) ? mem_rdata : '0;
    assign load_ready = (state == S_LOAD);
    assign cpu_hold   = (state == S_LOAD);
endmodule

// File: tb/tb_ks_memory.sv
// Directed bench for ks_memory: loader streaming, run-mode reads/writes, reset reload.
module tb_ks_memory;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ram_addr;
    logic [15:0] wr_data;
    logic        write_enable;
    logic [15:0] rd_data;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        cpu_hold;
    logic        load_done;

    int checks = 0;
    int errors = 0;

    ks_memory #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ram_addr     (ram_addr),
        .wr_data      (wr_data),
        .write_enable (write_enable),
        .rd_data      (rd_data),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        we;
        logic [15:0] wd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [15:0] exp, input string nm);
        ram_addr     = a;
        write_enable = 1'b0;
        tick();
        chk(nm, {16'h0, rd_data}, {16'h0, exp});
    endtask

    // Streams n words base+i with load_valid held high; returns done-pulse count.
    task automatic load_words(input int n, input logic [15:0] base, output int ready_cnt,
                              output int done_cnt);
        ready_cnt = 0;
        done_cnt  = 0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = base + 16'(i);
            if (load_ready === 1'b1) ready_cnt++;
            tick();
            if (load_done === 1'b1) done_cnt++;
        end
        load_valid = 1'b0;
    endtask

    initial begin
        int rc, dc, acc, done_cyc;
        bit seen;

        rst_n = 1'b0; ram_addr = '0; wr_data = '0; write_enable = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;

        vecs[0] = '{5'd5,  1'b0, 16'h0000, 16'h0105};
        vecs[1] = '{5'd3,  1'b1, 16'hBEEF, 16'h0103};
        vecs[2] = '{5'd3,  1'b0, 16'h0000, 16'hBEEF};
        vecs[3] = '{5'd0,  1'b0, 16'h0000, 16'h0100};
        vecs[4] = '{5'd31, 1'b0, 16'h0000, 16'h011F};
        vecs[5] = '{5'd31, 1'b1, 16'h7777, 16'h011F};
        vecs[6] = '{5'd31, 1'b0, 16'h0000, 16'h7777};
        vecs[7] = '{5'd7,  1'b0, 16'h0000, 16'h0107};

        tick();
        tick();
        chk("rst_load_ready", {31'h0, load_ready}, 32'd1);
        chk("rst_cpu_hold",   {31'h0, cpu_hold},   32'd1);
        chk("rst_load_done",  {31'h0, load_done},  32'd0);
        chk("rst_rd_data",    {16'h0, rd_data},    32'd0);
        rst_n = 1'b1;

        // Full load with load_valid held high.
        load_words(32, 16'h0100, rc, dc);
        chk("load1_ready_cycles", rc, 32);
        chk("load1_done_pulses",  dc, 1);
        chk("load1_done_now",   {31'h0, load_done},  32'd1);
        chk("load1_cpu_hold",   {31'h0, cpu_hold},   32'd0);
        chk("load1_load_ready", {31'h0, load_ready}, 32'd0);

        // Run-mode read/write table; each row's expected value is the read one cycle later.
        for (int i = 0; i < 8; i++) begin
            ram_addr     = vecs[i].addr;
            write_enable = vecs[i].we;
            wr_data      = vecs[i].wd;
            tick();
            chk($sformatf("run_vec%0d", i), {16'h0, rd_data}, {16'h0, vecs[i].exp_rd});
            if (i == 0) chk("done_one_cycle", {31'h0, load_done}, 32'd0);
        end
        write_enable = 1'b0;

        // load_start with a concurrent write, then a toggling-valid reload.
        ram_addr = 5'd10; wr_data = 16'h1234; write_enable = 1'b1; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ls_cpu_hold",   {31'h0, cpu_hold},   32'd1);
        chk("ls_load_ready", {31'h0, load_ready}, 32'd1);
        chk("ls_rd_zero",    {16'h0, rd_data},    32'd0);

        // write_enable stays high on addr 7 throughout the load and must be ignored.
        ram_addr = 5'd7; wr_data = 16'hFFFF; write_enable = 1'b1;
        acc = 0; seen = 0; done_cyc = -1;
        for (int c = 0; c < 100 && !seen; c++) begin
            load_valid = (c % 2 == 0);
            load_data  = 16'h0200 + 16'(acc);
            load_start = (c == 20);
            tick();
            if (load_valid) acc++;
            if (load_done === 1'b1) begin
                seen = 1;
                done_cyc = c;
            end
        end
        load_valid = 1'b0; load_start = 1'b0; write_enable = 1'b0;
        chk("tog_done_seen",  {31'h0, seen}, 32'd1);
        chk("tog_accepted",   acc, 32);
        chk("tog_done_cycle", done_cyc, 62);
        rd_chk(5'd7,  16'h0207, "tog_mem7_loader");
        rd_chk(5'd10, 16'h020A, "tog_mem10");
        rd_chk(5'd0,  16'h0200, "tog_mem0");
        rd_chk(5'd31, 16'h021F, "tog_mem31");

        // Reset in the middle of a load restarts at address 0.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_words(10, 16'h0300, rc, dc);
        rst_n = 1'b0; load_valid = 1'b1; load_data = 16'hDEAD;
        tick();
        rst_n = 1'b1; load_valid = 1'b0;
        chk("mid_rst_cpu_hold", {31'h0, cpu_hold}, 32'd1);
        chk("mid_rst_rd_zero",  {16'h0, rd_data},  32'd0);
        load_words(32, 16'hA000, rc, dc);
        chk("reload_done_pulses", dc, 1);
        chk("reload_cpu_hold", {31'h0, cpu_hold}, 32'd0);
        for (int a = 0; a < 32; a++)
            rd_chk(5'(a), 16'hA000 + 16'(a), $sformatf("reload_mem%0d", a));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
